// File: rtl/pipelined_cpu.sv
// Five-stage in-order RV32 subset CPU (IF/ID/EX/MEM/WB).
// Supports and/xor/sll/add/sub/mul, addi/srai, lw/sw and beq.
// EX-stage operand forwarding, load-use stall, and beq resolved in ID.
// Instruction memory, data memory and register file are loaded from outside
// by hierarchical access and are never cleared by reset.
module pipelined_cpu #(
    parameter int IMEM_WORDS = 256,
    parameter int DMEM_WORDS = 32
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic start_i,
    output logic Stall_o,
    output logic branch_o
);

    localparam int IA_W = $clog2(IMEM_WORDS);
    localparam int DA_W = $clog2(DMEM_WORDS);

    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;

    // Storage arrays (preloaded externally, not reset)
    logic [31:0] imem [IMEM_WORDS];
    logic [31:0] dmem [DMEM_WORDS];
    logic [31:0] regs [32];

    // Program counter
    logic [31:0] pc_q, pc_d;

    // IF/ID
    logic [31:0] if_id_instr_q, if_id_instr_d;
    logic [31:0] if_id_pc_q, if_id_pc_d;

    // ID/EX
    logic        id_ex_reg_write_q, id_ex_reg_write_d;
    logic        id_ex_mem_to_reg_q, id_ex_mem_to_reg_d;
    logic        id_ex_mem_read_q, id_ex_mem_read_d;
    logic        id_ex_mem_write_q, id_ex_mem_write_d;
    logic        id_ex_alu_src_q, id_ex_alu_src_d;
    logic [1:0]  id_ex_alu_op_q, id_ex_alu_op_d;
    logic [31:0] id_ex_rd1_q, id_ex_rd1_d;
    logic [31:0] id_ex_rd2_q, id_ex_rd2_d;
    logic [31:0] id_ex_imm_q, id_ex_imm_d;
    logic [9:0]  id_ex_funct_q, id_ex_funct_d;
    logic [4:0]  id_ex_rs1_q, id_ex_rs1_d;
    logic [4:0]  id_ex_rs2_q, id_ex_rs2_d;
    logic [4:0]  id_ex_rd_q, id_ex_rd_d;

    // EX/MEM
    logic        ex_mem_reg_write_q, ex_mem_reg_write_d;
    logic        ex_mem_mem_to_reg_q, ex_mem_mem_to_reg_d;
    logic        ex_mem_mem_write_q, ex_mem_mem_write_d;
    logic [31:0] ex_mem_alu_q, ex_mem_alu_d;
    logic [31:0] ex_mem_store_q, ex_mem_store_d;
    logic [4:0]  ex_mem_rd_q, ex_mem_rd_d;

    // MEM/WB
    logic        mem_wb_reg_write_q, mem_wb_reg_write_d;
    logic        mem_wb_mem_to_reg_q, mem_wb_mem_to_reg_d;
    logic [31:0] mem_wb_mem_data_q, mem_wb_mem_data_d;
    logic [31:0] mem_wb_alu_q, mem_wb_alu_d;
    logic [4:0]  mem_wb_rd_q, mem_wb_rd_d;

    // ID-stage decode results
    logic [6:0]  opcode;
    logic [4:0]  rs1, rs2, rd;
    logic [2:0]  funct3;
    logic [6:0]  funct7;
    logic        ctrl_reg_write, ctrl_mem_to_reg, ctrl_mem_read, ctrl_mem_write;
    logic        ctrl_alu_src, ctrl_branch;
    logic [1:0]  ctrl_alu_op;
    logic [31:0] imm_id, imm_b;
    logic [31:0] rf_rd1, rf_rd2;
    logic [31:0] branch_target;
    logic        stall, take_branch;

    // EX / MEM / WB datapath
    logic [31:0] fwd_a, fwd_b, op_b, alu_result;
    logic [31:0] mem_rdata, wb_data;

    assign opcode = if_id_instr_q[6:0];
    assign rd     = if_id_instr_q[11:7];
    assign funct3 = if_id_instr_q[14:12];
    assign rs1    = if_id_instr_q[19:15];
    assign rs2    = if_id_instr_q[24:20];
    assign funct7 = if_id_instr_q[31:25];

    assign imm_b  = {{20{if_id_instr_q[31]}}, if_id_instr_q[31], if_id_instr_q[7],
                     if_id_instr_q[30:25], if_id_instr_q[11:8]};
    assign branch_target = if_id_pc_q + (imm_b << 1);

    assign wb_data   = mem_wb_mem_to_reg_q ? mem_wb_mem_data_q : mem_wb_alu_q;
    assign mem_rdata = dmem[ex_mem_alu_q[DA_W+1:2]];

    // Main decoder: opcode to control bits and sign-extended immediate; unknown words (incl. NOP) give all zeros
    always_comb begin
        ctrl_reg_write  = 1'b0;
        ctrl_mem_to_reg = 1'b0;
        ctrl_mem_read   = 1'b0;
        ctrl_mem_write  = 1'b0;
        ctrl_alu_src    = 1'b0;
        ctrl_branch     = 1'b0;
        ctrl_alu_op     = 2'b00;
        imm_id          = 32'd0;
        case (opcode)
            OP_R: begin
                ctrl_reg_write = 1'b1;
                ctrl_alu_op    = 2'b10;
            end
            OP_IMM: begin
                ctrl_reg_write = 1'b1;
                ctrl_alu_src   = 1'b1;
                ctrl_alu_op    = 2'b11;
                imm_id         = {{20{if_id_instr_q[31]}}, if_id_instr_q[31:20]};
            end
            OP_LOAD: begin
                ctrl_reg_write  = 1'b1;
                ctrl_mem_to_reg = 1'b1;
                ctrl_mem_read   = 1'b1;
                ctrl_alu_src    = 1'b1;
                imm_id          = {{20{if_id_instr_q[31]}}, if_id_instr_q[31:20]};
            end
            OP_STORE: begin
                ctrl_mem_write = 1'b1;
                ctrl_alu_src   = 1'b1;
                imm_id         = {{20{if_id_instr_q[31]}}, if_id_instr_q[31:25], if_id_instr_q[11:7]};
            end
            OP_BRANCH: begin
                ctrl_branch = 1'b1;
                ctrl_alu_op = 2'b01;
                imm_id      = imm_b;
            end
            default: ;
        endcase
    end

    // Register-file read with same-cycle bypass of the value being written back
    always_comb begin
        rf_rd1 = regs[rs1];
        rf_rd2 = regs[rs2];
        if (mem_wb_reg_write_q && (mem_wb_rd_q == rs1)) rf_rd1 = wb_data;
        if (mem_wb_reg_write_q && (mem_wb_rd_q == rs2)) rf_rd2 = wb_data;
        if (rs1 == 5'd0) rf_rd1 = 32'd0;
        if (rs2 == 5'd0) rf_rd2 = 32'd0;
    end

    // Hazard unit and branch decision; a stall outranks a branch redirect
    always_comb begin
        stall       = id_ex_mem_read_q && ((id_ex_rd_q == rs1) || (id_ex_rd_q == rs2));
        branch_o    = ctrl_branch && (rf_rd1 == rf_rd2);
        take_branch = branch_o && !stall;
        Stall_o     = stall;
    end

    // EX operand forwarding: EX/MEM wins over MEM/WB, else the value read in ID
    always_comb begin
        fwd_a = id_ex_rd1_q;
        fwd_b = id_ex_rd2_q;
        if (ex_mem_reg_write_q && (ex_mem_rd_q != 5'd0) && (ex_mem_rd_q == id_ex_rs1_q))
            fwd_a = ex_mem_alu_q;
        else if (mem_wb_reg_write_q && (mem_wb_rd_q != 5'd0) && (mem_wb_rd_q == id_ex_rs1_q))
            fwd_a = wb_data;
        if (ex_mem_reg_write_q && (ex_mem_rd_q != 5'd0) && (ex_mem_rd_q == id_ex_rs2_q))
            fwd_b = ex_mem_alu_q;
        else if (mem_wb_reg_write_q && (mem_wb_rd_q != 5'd0) && (mem_wb_rd_q == id_ex_rs2_q))
            fwd_b = wb_data;
        op_b = id_ex_alu_src_q ? id_ex_imm_q : fwd_b;
    end

    // ALU: ALUOp 00 add (address), 01 sub, 10 R-type by {funct7,funct3}, 11 I-type by funct3
    always_comb begin
        alu_result = 32'd0;
        case (id_ex_alu_op_q)
            2'b00: alu_result = fwd_a + op_b;
            2'b01: alu_result = fwd_a - op_b;
            2'b10: begin
                case (id_ex_funct_q)
                    10'b0000000_000: alu_result = fwd_a + op_b;
                    10'b0100000_000: alu_result = fwd_a - op_b;
                    10'b0000000_001: alu_result = fwd_a << op_b[4:0];
                    10'b0000000_100: alu_result = fwd_a ^ op_b;
                    10'b0000000_111: alu_result = fwd_a & op_b;
                    10'b0000001_000: alu_result = fwd_a * op_b;
                    default:         alu_result = 32'd0;
                endcase
            end
            default: begin
                case (id_ex_funct_q[2:0])
                    3'b000:  alu_result = fwd_a + op_b;
                    3'b101:  alu_result = 32'($signed(fwd_a) >>> op_b[4:0]);
                    default: alu_result = 32'd0;
                endcase
            end
        endcase
    end

    // Next-state for PC and all pipeline registers.
    // With start_i low the PC holds and IF/ID takes bubbles, so in-flight work drains without re-executing.
    always_comb begin
        pc_d          = pc_q;
        if_id_instr_d = if_id_instr_q;
        if_id_pc_d    = if_id_pc_q;
        if (!stall) begin
            if (start_i) pc_d = take_branch ? branch_target : pc_q + 32'd4;
            if (take_branch || !start_i) begin
                if_id_instr_d = 32'd0;
                if_id_pc_d    = 32'd0;
            end else begin
                if_id_instr_d = imem[pc_q[IA_W+1:2]];
                if_id_pc_d    = pc_q;
            end
        end

        id_ex_reg_write_d  = stall ? 1'b0 : ctrl_reg_write;
        id_ex_mem_to_reg_d = stall ? 1'b0 : ctrl_mem_to_reg;
        id_ex_mem_read_d   = stall ? 1'b0 : ctrl_mem_read;
        id_ex_mem_write_d  = stall ? 1'b0 : ctrl_mem_write;
        id_ex_alu_src_d    = stall ? 1'b0 : ctrl_alu_src;
        id_ex_alu_op_d     = stall ? 2'b00 : ctrl_alu_op;
        id_ex_rd1_d        = rf_rd1;
        id_ex_rd2_d        = rf_rd2;
        id_ex_imm_d        = imm_id;
        id_ex_funct_d      = {funct7, funct3};
        id_ex_rs1_d        = rs1;
        id_ex_rs2_d        = rs2;
        id_ex_rd_d         = stall ? 5'd0 : rd;

        ex_mem_reg_write_d  = id_ex_reg_write_q;
        ex_mem_mem_to_reg_d = id_ex_mem_to_reg_q;
        ex_mem_mem_write_d  = id_ex_mem_write_q;
        ex_mem_alu_d        = alu_result;
        ex_mem_store_d      = fwd_b;
        ex_mem_rd_d         = id_ex_rd_q;

        mem_wb_reg_write_d  = ex_mem_reg_write_q;
        mem_wb_mem_to_reg_d = ex_mem_mem_to_reg_q;
        mem_wb_mem_data_d   = mem_rdata;
        mem_wb_alu_d        = ex_mem_alu_q;
        mem_wb_rd_d         = ex_mem_rd_q;
    end

    // PC and pipeline registers; asynchronous reset turns every stage into a bubble
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            pc_q                <= '0;
            if_id_instr_q       <= '0;
            if_id_pc_q          <= '0;
            id_ex_reg_write_q   <= '0;
            id_ex_mem_to_reg_q  <= '0;
            id_ex_mem_read_q    <= '0;
            id_ex_mem_write_q   <= '0;
            id_ex_alu_src_q     <= '0;
            id_ex_alu_op_q      <= '0;
            id_ex_rd1_q         <= '0;
            id_ex_rd2_q         <= '0;
            id_ex_imm_q         <= '0;
            id_ex_funct_q       <= '0;
            id_ex_rs1_q         <= '0;
            id_ex_rs2_q         <= '0;
            id_ex_rd_q          <= '0;
            ex_mem_reg_write_q  <= '0;
            ex_mem_mem_to_reg_q <= '0;
            ex_mem_mem_write_q  <= '0;
            ex_mem_alu_q        <= '0;
            ex_mem_store_q      <= '0;
            ex_mem_rd_q         <= '0;
            mem_wb_reg_write_q  <= '0;
            mem_wb_mem_to_reg_q <= '0;
            mem_wb_mem_data_q   <= '0;
            mem_wb_alu_q        <= '0;
            mem_wb_rd_q         <= '0;
        end else begin
            pc_q                <= pc_d;
            if_id_instr_q       <= if_id_instr_d;
            if_id_pc_q          <= if_id_pc_d;
            id_ex_reg_write_q   <= id_ex_reg_write_d;
            id_ex_mem_to_reg_q  <= id_ex_mem_to_reg_d;
            id_ex_mem_read_q    <= id_ex_mem_read_d;
            id_ex_mem_write_q   <= id_ex_mem_write_d;
            id_ex_alu_src_q     <= id_ex_alu_src_d;
            id_ex_alu_op_q      <= id_ex_alu_op_d;
            id_ex_rd1_q         <= id_ex_rd1_d;
            id_ex_rd2_q         <= id_ex_rd2_d;
            id_ex_imm_q         <= id_ex_imm_d;
            id_ex_funct_q       <= id_ex_funct_d;
            id_ex_rs1_q         <= id_ex_rs1_d;
            id_ex_rs2_q         <= id_ex_rs2_d;
            id_ex_rd_q          <= id_ex_rd_d;
            ex_mem_reg_write_q  <= ex_mem_reg_write_d;
            ex_mem_mem_to_reg_q <= ex_mem_mem_to_reg_d;
            ex_mem_mem_write_q  <= ex_mem_mem_write_d;
            ex_mem_alu_q        <= ex_mem_alu_d;
            ex_mem_store_q      <= ex_mem_store_d;
            ex_mem_rd_q         <= ex_mem_rd_d;
            mem_wb_reg_write_q  <= mem_wb_reg_write_d;
            mem_wb_mem_to_reg_q <= mem_wb_mem_to_reg_d;
            mem_wb_mem_data_q   <= mem_wb_mem_data_d;
            mem_wb_alu_q        <= mem_wb_alu_d;
            mem_wb_rd_q         <= mem_wb_rd_d;
        end
    end

    // Data-memory store and register-file write-back; contents survive reset
    always_ff @(posedge clk_i) begin
        if (ex_mem_mem_write_q) dmem[ex_mem_alu_q[DA_W+1:2]] <= ex_mem_store_q;
        if (mem_wb_reg_write_q && (mem_wb_rd_q != 5'd0)) regs[mem_wb_rd_q] <= wb_data;
    end

endmodule

// File: tb/tb_pipelined_cpu.sv
// Directed testbench for pipelined_cpu: short programs with hand-computed results.
module tb_pipelined_cpu;

    logic clk = 1'b0;
    logic rst_i;
    logic start_i;
    logic Stall_o;
    logic branch_o;

    int tests_run = 0;
    int tests_failed = 0;
    int stall_cnt;
    int flush_cnt;
    logic [31:0] pc_log [32];

    pipelined_cpu dut (
        .clk_i   (clk),
        .rst_i   (rst_i),
        .start_i (start_i),
        .Stall_o (Stall_o),
        .branch_o(branch_o)
    );

    always #5 clk = ~clk;

    // Tiny assembler helpers
    function automatic logic [31:0] enc_r(input logic [6:0] f7, input logic [4:0] rs2,
                                          input logic [4:0] rs1, input logic [2:0] f3,
                                          input logic [4:0] rd);
        return {f7, rs2, rs1, f3, rd, 7'b0110011};
    endfunction

    function automatic logic [31:0] enc_i(input logic [11:0] imm, input logic [4:0] rs1,
                                          input logic [2:0] f3, input logic [4:0] rd,
                                          input logic [6:0] op);
        return {imm, rs1, f3, rd, op};
    endfunction

    function automatic logic [31:0] enc_s(input logic [11:0] imm, input logic [4:0] rs2,
                                          input logic [4:0] rs1);
        return {imm[11:5], rs2, rs1, 3'b010, imm[4:0], 7'b0100011};
    endfunction

    function automatic logic [31:0] enc_b(input logic [12:0] imm, input logic [4:0] rs2,
                                          input logic [4:0] rs1);
        return {imm[12], imm[10:5], rs2, rs1, 3'b000, imm[4:1], imm[11], 7'b1100011};
    endfunction

    // Hold reset, clear all memories and registers
    task automatic clear_state();
        rst_i   = 1'b0;
        start_i = 1'b0;
        for (int i = 0; i < 256; i++) dut.imem[i] = 32'd0;
        for (int i = 0; i < 32; i++) dut.dmem[i] = 32'd0;
        for (int i = 0; i < 32; i++) dut.regs[i] = 32'd0;
        repeat (2) @(posedge clk);
        @(negedge clk);
    endtask

    // Release reset with start high and run a fixed number of cycles, logging PC / stalls / branches
    task automatic run(input int cycles);
        rst_i     = 1'b1;
        start_i   = 1'b1;
        stall_cnt = 0;
        flush_cnt = 0;
        for (int i = 0; i < cycles; i++) begin
            if (i < 32) pc_log[i] = dut.pc_q;
            if (Stall_o) stall_cnt++;
            if (branch_o) flush_cnt++;
            @(posedge clk);
            @(negedge clk);
        end
    endtask

    task automatic test_reset();
        rst_i   = 1'b0;
        start_i = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        tests_run++;
        if (dut.pc_q !== 32'd0) begin
            tests_failed++;
            $display("FAIL reset_pc: got %h expected 00000000", dut.pc_q);
        end
        tests_run++;
        if ({Stall_o, branch_o} !== 2'b00) begin
            tests_failed++;
            $display("FAIL reset_outputs: got %b expected 00", {Stall_o, branch_o});
        end
        $display("[TB] test_reset done");
    endtask

    task automatic test_alu_forward();
        clear_state();
        dut.imem[0] = enc_i(12'd3, 5'd0, 3'b000, 5'd1, 7'b0010011);       // addi x1,x0,3
        dut.imem[1] = enc_r(7'b0000000, 5'd1, 5'd1, 3'b000, 5'd2);         // add x2,x1,x1
        dut.imem[2] = enc_r(7'b0100000, 5'd1, 5'd2, 3'b000, 5'd3);         // sub x3,x2,x1
        run(8);
        tests_run++;
        if (dut.regs[1] !== 32'd3) begin
            tests_failed++;
            $display("FAIL alu_x1: got %0d expected 3", dut.regs[1]);
        end
        tests_run++;
        if (dut.regs[2] !== 32'd6) begin
            tests_failed++;
            $display("FAIL alu_x2: got %0d expected 6", dut.regs[2]);
        end
        tests_run++;
        if (dut.regs[3] !== 32'd3) begin
            tests_failed++;
            $display("FAIL alu_x3: got %0d expected 3", dut.regs[3]);
        end
        tests_run++;
        if (stall_cnt !== 0) begin
            tests_failed++;
            $display("FAIL alu_stalls: got %0d expected 0", stall_cnt);
        end
        $display("[TB] test_alu_forward x1=%0d x2=%0d x3=%0d stalls=%0d",
                 dut.regs[1], dut.regs[2], dut.regs[3], stall_cnt);
    endtask

    task automatic test_load_use();
        clear_state();
        dut.dmem[0] = 32'd5;
        dut.imem[0] = enc_i(12'd0, 5'd0, 3'b010, 5'd2, 7'b0000011);       // lw x2,0(x0)
        dut.imem[1] = enc_r(7'b0000000, 5'd2, 5'd2, 3'b000, 5'd3);         // add x3,x2,x2
        run(10);
        tests_run++;
        if (dut.regs[3] !== 32'd10) begin
            tests_failed++;
            $display("FAIL loaduse_x3: got %0d expected 10", dut.regs[3]);
        end
        tests_run++;
        if (stall_cnt !== 1) begin
            tests_failed++;
            $display("FAIL loaduse_stalls: got %0d expected 1", stall_cnt);
        end
        tests_run++;
        if ({pc_log[2], pc_log[3], pc_log[4]} !== {32'd8, 32'd8, 32'd12}) begin
            tests_failed++;
            $display("FAIL loaduse_pc: got %0d,%0d,%0d expected 8,8,12",
                     pc_log[2], pc_log[3], pc_log[4]);
        end
        $display("[TB] test_load_use x3=%0d stalls=%0d", dut.regs[3], stall_cnt);
    endtask

    task automatic test_store_mul();
        clear_state();
        dut.imem[0] = enc_i(12'd7, 5'd0, 3'b000, 5'd1, 7'b0010011);       // addi x1,x0,7
        dut.imem[1] = enc_i(12'd6, 5'd0, 3'b000, 5'd2, 7'b0010011);       // addi x2,x0,6
        dut.imem[2] = enc_r(7'b0000001, 5'd2, 5'd1, 3'b000, 5'd3);         // mul x3,x1,x2
        dut.imem[3] = enc_s(12'd4, 5'd3, 5'd0);                            // sw x3,4(x0)
        run(12);
        tests_run++;
        if (dut.dmem[1] !== 32'd42) begin
            tests_failed++;
            $display("FAIL store_dmem1: got %0d expected 42", dut.dmem[1]);
        end
        tests_run++;
        if (dut.regs[3] !== 32'd42) begin
            tests_failed++;
            $display("FAIL mul_x3: got %0d expected 42", dut.regs[3]);
        end
        $display("[TB] test_store_mul dmem[1]=%0d", dut.dmem[1]);
    endtask

    task automatic test_branch_taken();
        clear_state();
        dut.imem[0] = enc_b(13'd8, 5'd0, 5'd0);                            // beq x0,x0,8
        dut.imem[1] = enc_i(12'd1, 5'd0, 3'b000, 5'd5, 7'b0010011);       // addi x5,x0,1
        dut.imem[2] = enc_i(12'd2, 5'd0, 3'b000, 5'd6, 7'b0010011);       // addi x6,x0,2
        run(10);
        tests_run++;
        if (dut.regs[5] !== 32'd0) begin
            tests_failed++;
            $display("FAIL taken_x5: got %0d expected 0", dut.regs[5]);
        end
        tests_run++;
        if (dut.regs[6] !== 32'd2) begin
            tests_failed++;
            $display("FAIL taken_x6: got %0d expected 2", dut.regs[6]);
        end
        tests_run++;
        if (flush_cnt !== 1) begin
            tests_failed++;
            $display("FAIL taken_flushes: got %0d expected 1", flush_cnt);
        end
        tests_run++;
        if ({pc_log[0], pc_log[1], pc_log[2], pc_log[3]} !== {32'd0, 32'd4, 32'd8, 32'd12}) begin
            tests_failed++;
            $display("FAIL taken_pc: got %0d,%0d,%0d,%0d expected 0,4,8,12",
                     pc_log[0], pc_log[1], pc_log[2], pc_log[3]);
        end
        $display("[TB] test_branch_taken x5=%0d x6=%0d flushes=%0d",
                 dut.regs[5], dut.regs[6], flush_cnt);
    endtask

    task automatic test_branch_not_taken();
        clear_state();
        // beq reads x1 in ID before addi writes it back, so x1 holds its older value (nonzero) there
        dut.regs[1] = 32'd1;
        dut.imem[0] = enc_i(12'hff8, 5'd0, 3'b000, 5'd1, 7'b0010011);     // addi x1,x0,-8
        dut.imem[1] = enc_i({7'b0100000, 5'd1}, 5'd1, 3'b101, 5'd2, 7'b0010011); // srai x2,x1,1
        dut.imem[2] = enc_b(13'd8, 5'd0, 5'd1);                            // beq x1,x0,8
        dut.imem[3] = enc_i(12'd3, 5'd0, 3'b000, 5'd4, 7'b0010011);       // addi x4,x0,3
        dut.imem[4] = enc_r(7'b0000000, 5'd4, 5'd4, 3'b001, 5'd5);         // sll x5,x4,x4
        dut.imem[5] = enc_r(7'b0000000, 5'd4, 5'd5, 3'b100, 5'd6);         // xor x6,x5,x4
        dut.imem[6] = enc_r(7'b0000000, 5'd4, 5'd6, 3'b111, 5'd7);         // and x7,x6,x4
        run(14);
        tests_run++;
        if (dut.regs[2] !== 32'hffff_fffc) begin
            tests_failed++;
            $display("FAIL srai_x2: got %h expected fffffffc", dut.regs[2]);
        end
        tests_run++;
        if (dut.regs[4] !== 32'd3) begin
            tests_failed++;
            $display("FAIL nt_x4: got %0d expected 3", dut.regs[4]);
        end
        tests_run++;
        if (dut.regs[5] !== 32'd24) begin
            tests_failed++;
            $display("FAIL sll_x5: got %0d expected 24", dut.regs[5]);
        end
        tests_run++;
        if (dut.regs[6] !== 32'd27) begin
            tests_failed++;
            $display("FAIL xor_x6: got %0d expected 27", dut.regs[6]);
        end
        tests_run++;
        if (dut.regs[7] !== 32'd3) begin
            tests_failed++;
            $display("FAIL and_x7: got %0d expected 3", dut.regs[7]);
        end
        tests_run++;
        if (flush_cnt !== 0) begin
            tests_failed++;
            $display("FAIL nt_flushes: got %0d expected 0", flush_cnt);
        end
        $display("[TB] test_branch_not_taken x2=%h x5=%0d x6=%0d x7=%0d flushes=%0d",
                 dut.regs[2], dut.regs[5], dut.regs[6], dut.regs[7], flush_cnt);
    endtask

    task automatic test_reset_midrun();
        clear_state();
        dut.imem[0] = enc_i(12'd3, 5'd0, 3'b000, 5'd1, 7'b0010011);       // addi x1,x0,3
        dut.imem[1] = enc_r(7'b0000000, 5'd1, 5'd1, 3'b000, 5'd2);         // add x2,x1,x1
        dut.imem[2] = enc_r(7'b0100000, 5'd1, 5'd2, 3'b000, 5'd3);         // sub x3,x2,x1
        run(5);
        // Asynchronous reset away from any clock edge
        #2 rst_i = 1'b0;
        #1;
        tests_run++;
        if (dut.pc_q !== 32'd0) begin
            tests_failed++;
            $display("FAIL midreset_pc: got %0d expected 0", dut.pc_q);
        end
        tests_run++;
        if ({dut.if_id_instr_q, dut.id_ex_rd_q, dut.ex_mem_rd_q, dut.mem_wb_rd_q, dut.ex_mem_alu_q} !== '0) begin
            tests_failed++;
            $display("FAIL midreset_pipe: got ifid=%h idex_rd=%0d exmem_rd=%0d memwb_rd=%0d expected all 0",
                     dut.if_id_instr_q, dut.id_ex_rd_q, dut.ex_mem_rd_q, dut.mem_wb_rd_q);
        end
        repeat (2) @(posedge clk);
        @(negedge clk);
        tests_run++;
        if (dut.regs[1] !== 32'd3) begin
            tests_failed++;
            $display("FAIL midreset_keep_x1: got %0d expected 3", dut.regs[1]);
        end
        tests_run++;
        if (dut.regs[2] !== 32'd0) begin
            tests_failed++;
            $display("FAIL midreset_squash_x2: got %0d expected 0", dut.regs[2]);
        end
        $display("[TB] test_reset_midrun pc=%0d x1=%0d x2=%0d", dut.pc_q, dut.regs[1], dut.regs[2]);
    endtask

    task automatic test_start_gating();
        // Program from test_reset_midrun is still in imem; regs x1=3 retained, clear it
        dut.regs[1] = 32'd0;
        rst_i   = 1'b1;
        start_i = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        tests_run++;
        if (dut.pc_q !== 32'd0) begin
            tests_failed++;
            $display("FAIL start_idle_pc: got %0d expected 0", dut.pc_q);
        end
        start_i = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        start_i = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        tests_run++;
        if (dut.pc_q !== 32'd8) begin
            tests_failed++;
            $display("FAIL start_hold_pc: got %0d expected 8", dut.pc_q);
        end
        repeat (4) @(posedge clk);
        @(negedge clk);
        tests_run++;
        if ({dut.regs[1], dut.regs[2], dut.regs[3]} !== {32'd3, 32'd6, 32'd0}) begin
            tests_failed++;
            $display("FAIL start_drain: got x1=%0d x2=%0d x3=%0d expected 3,6,0",
                     dut.regs[1], dut.regs[2], dut.regs[3]);
        end
        $display("[TB] test_start_gating pc=%0d x2=%0d x3=%0d", dut.pc_q, dut.regs[2], dut.regs[3]);
    endtask

    initial begin
        rst_i   = 1'b0;
        start_i = 1'b0;
        test_reset();
        test_alu_forward();
        test_load_use();
        test_store_mul();
        test_branch_taken();
        test_branch_not_taken();
        test_reset_midrun();
        test_start_gating();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
